truth_table_sequencer: RTL and testbench



---
 rtl/truth_table_sequencer.sv | 135 +++++++++++++
 tb/tb_truth_table_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// Exhaustive truth-table sweeper: drives every input vector, samples reference/DUT outputs, tallies results.
// Optional macro TT_CAPTURE_EN adds the TT port holding the captured DUT truth table.
module truth_table_sequencer #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  output logic [N_IN-1:0] VEC,
  input  logic            F_REF,
  input  logic            F_DUT,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [N_IN:0]   ERR_CNT,
  output logic [N_IN:0]   ONES_CNT,
  output logic [N_IN-1:0] FIRST_ERR
`ifdef TT_CAPTURE_EN
  ,
  output logic [(1<<N_IN)-1:0] TT
`endif
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic [N_IN-1:0] first_q, first_d;
  logic            pass_q, pass_d;
`ifdef TT_CAPTURE_EN
  logic [(1<<N_IN)-1:0] tt_q, tt_d;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ones_d  = ones_q;
    first_d = first_q;
    pass_d  = pass_q;
`ifdef TT_CAPTURE_EN
    tt_d    = tt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          ones_d  = '0;
          first_d = '0;
          pass_d  = 1'b0;
`ifdef TT_CAPTURE_EN
          tt_d    = '0;
`endif
        end
      end
      ST_RUN: begin
        if (cnt_q != SETTLE_C) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          if (F_REF != F_DUT) begin
            err_d = err_q + 1'b1;
            if (err_q == '0) first_d = vec_q;
          end
          if (F_DUT) ones_d = ones_q + 1'b1;
`ifdef TT_CAPTURE_EN
          tt_d[vec_q] = F_DUT;
`endif
          // PASS uses the count including this final sample
          if (vec_q == '1) begin
            state_d = ST_FIN;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + 1'b1;
            cnt_d = '0;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ones_q  <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
`ifdef TT_CAPTURE_EN
      tt_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ones_q  <= ones_d;
      first_q <= first_d;
      pass_q  <= pass_d;
`ifdef TT_CAPTURE_EN
      tt_q    <= tt_d;
`endif
    end
  end

  assign VEC       = vec_q;
  assign BUSY      = (state_q == ST_RUN);
  assign DONE      = (state_q == ST_FIN);
  assign PASS      = pass_q;
  assign ERR_CNT   = err_q;
  assign ONES_CNT  = ones_q;
  assign FIRST_ERR = first_q;
`ifdef TT_CAPTURE_EN
  assign TT        = tt_q;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench for truth_table_sequencer: three instances with SETTLE = 1, 0 and 2.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] ref_tt;
  int          mode;
  int          sel;
  int          n_checks = 0;
  int          n_errors = 0;

  // a: SETTLE=1, b: SETTLE=0, c: SETTLE=2
  logic        start_a, start_b, start_c;
  logic [3:0]  vec_a, vec_b, vec_c;
  logic        fref_a, fref_b, fref_c, fdut_a, fdut_b, fdut_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;
  logic [4:0]  err_a, err_b, err_c, ones_a, ones_b, ones_c;
  logic [3:0]  first_a, first_b, first_c;
  logic [15:0] tt_a, tt_b, tt_c;

  // F_DUT for c is wrong during the first cycle each vector is applied
  logic [3:0]  vec_c_d;
  logic        busy_c_d;
  logic        glitch_c;
  always @(posedge clk) begin
    vec_c_d  <= vec_c;
    busy_c_d <= busy_c;
  end
  assign glitch_c = busy_c && ((vec_c != vec_c_d) || !busy_c_d);

  function automatic logic dut_fn(input logic [15:0] tbl, input int m,
                                  input logic [3:0] v, input logic g);
    logic r;
    r = tbl[v];
    case (m)
      1:       return ~r;
      2:       return (v == 4'd10) ? ~r : r;
      3:       return g ? ~r : r;
      default: return r;
    endcase
  endfunction

  assign fref_a = ref_tt[vec_a];
  assign fref_b = ref_tt[vec_b];
  assign fref_c = ref_tt[vec_c];
  assign fdut_a = dut_fn(ref_tt, mode, vec_a, 1'b0);
  assign fdut_b = dut_fn(ref_tt, mode, vec_b, 1'b0);
  assign fdut_c = dut_fn(ref_tt, mode, vec_c, glitch_c);

`ifndef TT_CAPTURE_EN
  assign tt_a = '0;
  assign tt_b = '0;
  assign tt_c = '0;
`endif

  truth_table_sequencer #(.N_IN(4), .SETTLE(1)) u_dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .VEC(vec_a), .F_REF(fref_a), .F_DUT(fdut_a),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR_CNT(err_a), .ONES_CNT(ones_a),
    .FIRST_ERR(first_a)
`ifdef TT_CAPTURE_EN
    , .TT(tt_a)
`endif
  );

  truth_table_sequencer #(.N_IN(4), .SETTLE(0)) u_dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .VEC(vec_b), .F_REF(fref_b), .F_DUT(fdut_b),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR_CNT(err_b), .ONES_CNT(ones_b),
    .FIRST_ERR(first_b)
`ifdef TT_CAPTURE_EN
    , .TT(tt_b)
`endif
  );

  truth_table_sequencer #(.N_IN(4), .SETTLE(2)) u_dut_c (
    .CLK(clk), .RST(rst), .START(start_c), .VEC(vec_c), .F_REF(fref_c), .F_DUT(fdut_c),
    .BUSY(busy_c), .DONE(done_c), .PASS(pass_c), .ERR_CNT(err_c), .ONES_CNT(ones_c),
    .FIRST_ERR(first_c)
`ifdef TT_CAPTURE_EN
    , .TT(tt_c)
`endif
  );

  logic [3:0]  o_vec, o_first;
  logic        o_busy, o_done, o_pass;
  logic [4:0]  o_err, o_ones;
  logic [15:0] o_tt;
  always_comb begin
    o_vec = vec_a; o_busy = busy_a; o_done = done_a; o_pass = pass_a;
    o_err = err_a; o_ones = ones_a; o_first = first_a; o_tt = tt_a;
    case (sel)
      1: begin
        o_vec = vec_b; o_busy = busy_b; o_done = done_b; o_pass = pass_b;
        o_err = err_b; o_ones = ones_b; o_first = first_b; o_tt = tt_b;
      end
      2: begin
        o_vec = vec_c; o_busy = busy_c; o_done = done_c; o_pass = pass_c;
        o_err = err_c; o_ones = ones_c; o_first = first_c; o_tt = tt_c;
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [4:0]  err;
    logic [4:0]  ones;
    logic [3:0]  first;
    logic        pass;
    logic [15:0] tt;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_expected(input int m);
    exp_t e;
    logic r, d;
    e.err = '0; e.ones = '0; e.first = '0; e.tt = '0;
    for (int v = 0; v < 16; v++) begin
      r = ref_tt[v];
      if (m == 1)                d = ~r;
      else if (m == 2 && v == 10) d = ~r;
      else                       d = r;
      if (r != d) begin
        if (e.err == 5'd0) e.first = 4'(v);
        e.err = e.err + 5'd1;
      end
      if (d) e.ones = e.ones + 5'd1;
      e.tt[v] = d;
    end
    e.pass = (e.err == 5'd0);
    exp_q.push_back(e);
  endtask

  task automatic compare_result();
    exp_t e;
    check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("err_cnt", 32'(o_err), 32'(e.err));
    check("ones_cnt", 32'(o_ones), 32'(e.ones));
    check("first_err", 32'(o_first), 32'(e.first));
    check("pass", 32'(o_pass), 32'(e.pass));
`ifdef TT_CAPTURE_EN
    check("tt", 32'(o_tt), 32'(e.tt));
`endif
  endtask

  task automatic set_start(input int s, input logic v);
    case (s)
      1:       start_b = v;
      2:       start_c = v;
      default: start_a = v;
    endcase
  endtask

  task automatic sweep(input int s, input int m, input int settle, input bit pulse_mid);
    int n;
    bit got;
    sel  = s;
    mode = m;
    @(negedge clk);
    set_start(s, 1'b1);
    push_expected(m);
    @(posedge clk); #1;
    check("accept_busy", 32'(o_busy), 32'd1);
    check("accept_vec", 32'(o_vec), 32'd0);
    set_start(s, 1'b0);
    n = 0; got = 1'b0;
    while (n < 200 && !got) begin
      @(posedge clk); #1;
      n++;
      if (o_done) got = 1'b1;
      else if (pulse_mid) set_start(s, (n == 7) || (n == 19));
    end
    set_start(s, 1'b0);
    check("done_latency", got ? 32'(n) : 32'hFFFF_FFFF, 32'(16 * (settle + 1)));
    check("fin_busy", 32'(o_busy), 32'd0);
    compare_result();
    @(posedge clk); #1;
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("vec_hold", 32'(o_vec), 32'd15);
    check("idle_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    int exp_vec, dones, last, seen;
    ref_tt  = 16'h752F;
    mode    = 0;
    sel     = 0;
    rst     = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vec", 32'(vec_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_ones", 32'(ones_a), 32'd0);
    check("rst_first", 32'(first_a), 32'd0);
    check("rst_tt", 32'(tt_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    sweep(0, 0, 1, 1'b0);
    sweep(0, 1, 1, 1'b0);
    sweep(0, 2, 1, 1'b1);

    // asynchronous reset in the middle of a sweep
    sel = 0; mode = 0;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (vec_a == 4'd7) break;
      @(posedge clk); #1;
    end
    check("vec7_reached", 32'(vec_a), 32'd7);
    #2 rst = 1'b1;
    #1;
    check("arst_vec", 32'(vec_a), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_err", 32'(err_a), 32'd0);
    check("arst_ones", 32'(ones_a), 32'd0);
    check("arst_done", 32'(done_a), 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) seen = 1;
    end
    check("no_done_after_rst", 32'(seen), 32'd0);
    sweep(0, 0, 1, 1'b0);

    // SETTLE=0 with START held high: back-to-back sweeps
    sel = 1; mode = 0;
    repeat (3) push_expected(0);
    @(negedge clk); start_b = 1'b1;
    exp_vec = 0; dones = 0; last = -1;
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(posedge clk); #1;
      if (busy_b) begin
        check("vec_step", 32'(vec_b), 32'(exp_vec));
        exp_vec++;
      end
      if (done_b) begin
        check("sweep_len", 32'(exp_vec), 32'd16);
        check("fin_not_busy", 32'(busy_b), 32'd0);
        if (last >= 0) check("done_period", 32'(cyc - last), 32'd18);
        last = cyc;
        exp_vec = 0;
        compare_result();
        dones++;
        if (dones == 3) break;
      end
    end
    start_b = 1'b0;
    check("held_dones", 32'(dones), 32'd3);

    // SETTLE=2, DUT wrong only in the first cycle of each vector
    sweep(2, 3, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
